// File: rtl/tt_serial_pkg.sv
// Shared definitions for the bit-serial adder tile: FSM encoding and the
// bidirectional pin map.
package tt_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions on uio_in / uio_out.
  localparam int IDX_LOAD_A = 0;
  localparam int IDX_LOAD_B = 1;
  localparam int IDX_START  = 2;
  localparam int IDX_BUSY   = 3;
  localparam int IDX_DONE   = 4;
  localparam int IDX_COUT   = 5;

  localparam logic [7:0] UIO_OE_MASK = 8'h38;

endpackage

// File: rtl/ha_cell.sv
// Half-adder cell, the same arithmetic as the combinational half-adder tile.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/tt_um_bit_serial_adder.sv
// Bit-serial adder tile: two operands are loaded, then added LSB-first one
// bit per enabled clock through a full adder built from two half-adder cells.
module tt_um_bit_serial_adder
  import tt_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Handshake: load_a/load_b/start are level-sampled on each enabled edge in
  // IDLE or DONE; loads win over start; all three are ignored while busy.
  logic load_a, load_b, start, any_load;
  assign load_a   = uio_in[IDX_LOAD_A];
  assign load_b   = uio_in[IDX_LOAD_B];
  assign start    = uio_in[IDX_START];
  assign any_load = load_a | load_b;

  logic unused_bits;
  assign unused_bits = &{1'b0, uio_in[7:3], ui_in};

  state_t           state;
  logic [WIDTH-1:0] opa, opb, sum;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             busy, done, carry_out;

  // Per-bit full adder: two half adders plus an OR for the carry.
  logic ha0_s, ha0_c, fa_s, ha1_c, fa_c;

  ha_cell u_ha0 (
    .a (opa[0]),
    .b (opb[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  ha_cell u_ha1 (
    .a (ha0_s),
    .b (carry),
    .s (fa_s),
    .c (ha1_c)
  );

  assign fa_c = ha0_c | ha1_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      sum       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE, DONE: begin
          if (any_load) begin
            if (load_a) opa <= ui_in[WIDTH-1:0];
            if (load_b) opb <= ui_in[WIDTH-1:0];
            // sum and carry_out keep the previous result until the next start.
            state <= IDLE;
            done  <= 1'b0;
          end else if (start) begin
            state     <= RUN;
            sum       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            carry_out <= 1'b0;
          end
        end
        RUN: begin
          carry <= fa_c;
          opa   <= {1'b0, opa[WIDTH-1:1]};
          opb   <= {1'b0, opb[WIDTH-1:1]};
          sum   <= {fa_s, sum[WIDTH-1:1]};
          if (cnt == LAST_BIT) begin
            cnt       <= '0;
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            carry_out <= fa_c;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign uo_out = 8'(sum);
  assign uio_oe = UIO_OE_MASK;

  always_comb begin
    uio_out           = '0;
    uio_out[IDX_BUSY] = busy;
    uio_out[IDX_DONE] = done;
    uio_out[IDX_COUT] = carry_out;
  end

endmodule

// File: tb/tb_tt_um_bit_serial_adder.sv
// Self-checking bench for the bit-serial adder tile; expected results come
// from plain integer addition of the operands.
module tb_tt_um_bit_serial_adder;

  localparam int W = 8;
  localparam logic [31:0] MASK = (32'd1 << W) - 1;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected {carry_out, sum} results, pushed at start.
  logic [W:0] exp_q[$];

  tt_um_bit_serial_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs set beforehand are captured, outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    step();
    rst_n  = 1'b1;
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    uio_in = 8'h01; ui_in = a; step();
    uio_in = 8'h02; ui_in = b; step();
    uio_in = 8'h00; ui_in = 8'h00;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    logic [31:0] total;
    total = (32'(a) & MASK) + (32'(b) & MASK);
    exp_q.push_back(total[W:0]);
    uio_in = 8'h04; step();
    uio_in = 8'h00;
  endtask

  // Waits for done with a cycle bound and scores latency and result.
  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    logic [W:0] exp;
    n = 0;
    while (uio_out[4] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, exp_cycles);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_sum"}, uo_out, 32'(exp[W-1:0]));
    check({tag, "_cout"}, uio_out[5], exp[W]);
    check({tag, "_busy"}, uio_out[3], 0);
  endtask

  task automatic add_op(input logic [7:0] a, input logic [7:0] b, input string tag);
    load_ab(a, b);
    start_op(a, b);
    wait_done(tag, W);
  endtask

  // Sum register after n RUN edges: low n result bits sitting at the top.
  function automatic logic [31:0] partial(input logic [7:0] a, input logic [7:0] b, input int n);
    logic [31:0] total;
    total = (32'(a) + 32'(b)) & ((32'd1 << n) - 1);
    return (total << (W - n)) & MASK;
  endfunction

  initial begin
    logic [7:0] ra, rb;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    step();
    do_reset();
    check("rst_uo_out", uo_out, 0);
    check("rst_uio_out", uio_out, 0);
    check("uio_oe", uio_oe, 8'h38);

    add_op(8'h5A, 8'h3C, "a5a_b3c");

    add_op(8'hFF, 8'h01, "aff_b01");
    for (int i = 0; i < 3; i++) begin
      step();
      check("done_hold", uio_out[4], 1);
    end
    check("done_hold_sum", uo_out, 8'h00);

    add_op(8'hFF, 8'hFF, "aff_bff");
    uio_in = 8'h02; ui_in = 8'h01; step(); uio_in = 8'h00;
    check("load_clears_done", uio_out[4], 0);
    check("load_keeps_sum", uo_out, 8'hFE);
    check("load_keeps_cout", uio_out[5], 1);

    // Loads and start inside RUN are ignored.
    load_ab(8'h12, 8'h34);
    start_op(8'h12, 8'h34);
    check("run_busy", uio_out[3], 1);
    step(); step(); step();
    uio_in = 8'h05; ui_in = 8'h00; step(); uio_in = 8'h00;
    wait_done("run_ignore", W - 4);

    // Reset in the middle of a run.
    load_ab(8'h11, 8'h22);
    start_op(8'h11, 8'h22);
    for (int i = 0; i < 4; i++) step();
    do_reset();
    exp_q.delete();
    check("midrst_uo_out", uo_out, 0);
    check("midrst_uio_out", uio_out, 0);
    add_op(8'h80, 8'h80, "a80_b80");

    // Enable low freezes a run part-way.
    load_ab(8'h6B, 8'h2D);
    start_op(8'h6B, 8'h2D);
    step(); step(); step();
    check("pre_freeze_sum", uo_out, partial(8'h6B, 8'h2D, 3));
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("freeze_sum", uo_out, partial(8'h6B, 8'h2D, 3));
      check("freeze_busy", uio_out[3], 1);
    end
    ena = 1'b1;
    wait_done("after_freeze", W - 3);

    // Load and start together: the load wins.
    uio_in = 8'h05; ui_in = 8'h07; step(); uio_in = 8'h00;
    check("load_wins_busy", uio_out[3], 0);
    check("load_wins_done", uio_out[4], 0);
    uio_in = 8'h02; ui_in = 8'h09; step(); uio_in = 8'h00;
    start_op(8'h07, 8'h09);
    wait_done("a07_b09", W);

    // Randomised operand pairs.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      add_op(ra, rb, "rand");
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
